// File: rtl/ysyx_22041211_wbu.sv
// Write-back stage: captures one retiring result, pulses the GPR/CSR write ports for one
// cycle, then holds wb_valid_o until fetch accepts it and counts the retirement.
module ysyx_22041211_wbu #(
   parameter int DATA_LEN = 32,
   parameter int CNT_LEN  = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lsu_valid_i,
   output logic                wb_ready_o,
   input  logic                wd_i,
   input  logic [4:0]          wreg_i,
   input  logic [DATA_LEN-1:0] wdata_i,
   input  logic                csr_wen_i,
   input  logic [11:0]         csr_addr_i,
   input  logic [DATA_LEN-1:0] csr_wdata_i,
   input  logic                ifu_ready_i,
   output logic                reg_wen_o,
   output logic [4:0]          reg_waddr_o,
   output logic [DATA_LEN-1:0] reg_wdata_o,
   output logic                csr_wen_o,
   output logic [11:0]         csr_waddr_o,
   output logic [DATA_LEN-1:0] csr_wdata_o,
   output logic                wb_valid_o,
   output logic [CNT_LEN-1:0]  retire_cnt_o
);

   typedef enum logic [1:0] {
      WB_IDLE  = 2'b00,
      WB_WRITE = 2'b01,
      WB_DONE  = 2'b10
   } wb_state_e;

   wb_state_e           state_q, state_d;
   logic                wd_q;
   logic [4:0]          wreg_q;
   logic [DATA_LEN-1:0] wdata_q;
   logic                csr_wen_q;
   logic [11:0]         csr_addr_q;
   logic [DATA_LEN-1:0] csr_wdata_q;
   logic [CNT_LEN-1:0]  cnt_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= WB_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = WB_IDLE;
      case (state_q)
         WB_IDLE:  state_d = lsu_valid_i ? WB_WRITE : WB_IDLE;
         WB_WRITE: state_d = WB_DONE;
         WB_DONE:  state_d = ifu_ready_i ? WB_IDLE : WB_DONE;
         default:  state_d = WB_IDLE;
      endcase
   end

   // Holding registers only load in IDLE, so upstream changes while busy are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q        <= 1'b0;
         wreg_q      <= '0;
         wdata_q     <= '0;
         csr_wen_q   <= 1'b0;
         csr_addr_q  <= '0;
         csr_wdata_q <= '0;
      end else if (state_q == WB_IDLE && lsu_valid_i) begin
         wd_q        <= wd_i;
         wreg_q      <= wreg_i;
         wdata_q     <= wdata_i;
         csr_wen_q   <= csr_wen_i;
         csr_addr_q  <= csr_addr_i;
         csr_wdata_q <= csr_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                   cnt_q <= '0;
      else if (state_q == WB_DONE && ifu_ready_i) cnt_q <= cnt_q + CNT_LEN'(1);
   end

   always_comb begin
      wb_ready_o = 1'b0;
      wb_valid_o = 1'b0;
      reg_wen_o  = 1'b0;
      csr_wen_o  = 1'b0;
      case (state_q)
         WB_IDLE:  wb_ready_o = 1'b1;
         WB_WRITE: begin
            reg_wen_o = wd_q & (wreg_q != 5'd0);
            csr_wen_o = csr_wen_q;
         end
         WB_DONE:  wb_valid_o = 1'b1;
         default:  wb_ready_o = 1'b0;
      endcase
   end

   assign reg_waddr_o  = wreg_q;
   assign reg_wdata_o  = wdata_q;
   assign csr_waddr_o  = csr_addr_q;
   assign csr_wdata_o  = csr_wdata_q;
   assign retire_cnt_o = cnt_q;

endmodule
